room_tilemap: RTL

Parametrised, RAM-backed successor to the hard-coded per-level room decoder. It classifies each VGA pixel against a writable tile map, with one map per level and a horizontal camera scroll. It sits between the VGA controller and the colour mapper / sprite ROMs. It supplies barrier and texture-class flags plus a texel address, with fixed 2-cycle latency.

---
 rtl/room_tilemap.sv | 135 +++++++++++++
 1 files changed

// File: rtl/room_tilemap.sv
// Tile-map room classifier: per-pixel barrier/texture flags and texel address, 2-cycle latency.
// Optional ROOM_TILEMAP_WRAP_EN: camera and world X wrap modulo the map width instead of clamping.
module room_tilemap #(
  parameter int TILE_W     = 20,
  parameter int TILE_H     = 20,
  parameter int MAP_COLS   = 64,
  parameter int MAP_ROWS   = 24,
  parameter int NUM_LEVELS = 4,
  parameter int LW         = $clog2(NUM_LEVELS)
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          frame_clk_rising,
  input  logic [LW-1:0]                 level_num,
  input  logic [3:0]                    scroll_step,
  input  logic [9:0]                    DrawX,
  input  logic [9:0]                    DrawY,
  input  logic                          map_we,
  input  logic [LW-1:0]                 map_wlevel,
  input  logic [$clog2(MAP_ROWS)-1:0]   map_wrow,
  input  logic [$clog2(MAP_COLS)-1:0]   map_wcol,
  input  logic [2:0]                    map_wdata,
  output logic [11:0]                   scroll_x,
  output logic                          pix_valid,
  output logic                          is_barrier,
  output logic                          is_dirt,
  output logic                          is_brick,
  output logic                          is_pipe,
  output logic [10:0]                   barrier_address
);
  localparam int WORLD = MAP_COLS * TILE_W;
  localparam int SMAX  = WORLD - 640;
  localparam int DEPTH = NUM_LEVELS * MAP_ROWS * MAP_COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam int TXW   = $clog2(TILE_W);
  localparam int TYW   = $clog2(TILE_H);

  logic [LW-1:0]      active_level;
  logic signed [13:0] scroll_sum;
  logic [11:0]        scroll_nxt;

  always_comb begin
    scroll_sum = $signed({2'b00, scroll_x}) + $signed({{10{scroll_step[3]}}, scroll_step});
    scroll_nxt = scroll_sum[11:0];
`ifdef ROOM_TILEMAP_WRAP_EN
    if (scroll_sum < 0)           scroll_nxt = 12'(scroll_sum + WORLD);
    else if (scroll_sum >= WORLD) scroll_nxt = 12'(scroll_sum - WORLD);
`else
    if (scroll_sum < 0)           scroll_nxt = '0;
    else if (scroll_sum > SMAX)   scroll_nxt = 12'(SMAX);
`endif
  end

  // A level change restarts the camera at the left edge and drops this frame's step.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      scroll_x     <= '0;
      active_level <= '0;
    end else if (frame_clk_rising) begin
      active_level <= level_num;
      scroll_x     <= (level_num != active_level) ? 12'd0 : scroll_nxt;
    end
  end

  logic [12:0]    sum_x, world_x, col;
  logic [9:0]     row;
  logic           x_ok, in_range_d;
  logic [AW-1:0]  rd_addr, wr_addr;
  logic [TXW-1:0] tx_d;
  logic [TYW-1:0] ty_d;
  logic           wr_ok;
  int             wa;

  always_comb begin
    sum_x   = {3'b000, DrawX} + {1'b0, scroll_x};
`ifdef ROOM_TILEMAP_WRAP_EN
    world_x = 13'(sum_x % WORLD);
    x_ok    = 1'b1;
`else
    world_x = sum_x;
    x_ok    = (world_x < WORLD);
`endif
    col        = 13'(world_x / TILE_W);
    row        = 10'(DrawY / TILE_H);
    in_range_d = (DrawX < 10'd640) && (row < MAP_ROWS) && x_ok;
    rd_addr    = in_range_d ? AW'((int'(active_level) * MAP_ROWS + int'(row)) * MAP_COLS + int'(col)) : '0;
    tx_d       = TXW'(world_x % TILE_W);
    ty_d       = TYW'(DrawY % TILE_H);
    wa         = (int'(map_wlevel) * MAP_ROWS + int'(map_wrow)) * MAP_COLS + int'(map_wcol);
    wr_addr    = AW'(wa);
    wr_ok      = map_we && (map_wrow < MAP_ROWS) && (wa < DEPTH);
  end

  // Contents are never reset; read-before-write gives old data on a same-cell collision.
  logic [2:0] mem [DEPTH];
  logic [2:0] rd_data;

  always_ff @(posedge Clk) begin
    if (wr_ok) mem[wr_addr] <= map_wdata;
    rd_data <= mem[rd_addr];
  end

  logic           in_range_q;
  logic [TXW-1:0] tx_q;
  logic [TYW-1:0] ty_q;
  logic [1:0]     vld_pipe;
  logic           hit;

  assign pix_valid = vld_pipe[1];
  assign hit       = in_range_q && (rd_data >= 3'd1) && (rd_data <= 3'd4);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld_pipe        <= '0;
      in_range_q      <= 1'b0;
      tx_q            <= '0;
      ty_q            <= '0;
      is_barrier      <= 1'b0;
      is_dirt         <= 1'b0;
      is_brick        <= 1'b0;
      is_pipe         <= 1'b0;
      barrier_address <= '0;
    end else begin
      vld_pipe        <= {vld_pipe[0], 1'b1};
      in_range_q      <= in_range_d;
      tx_q            <= tx_d;
      ty_q            <= ty_d;
      is_barrier      <= hit;
      is_dirt         <= in_range_q && (rd_data == 3'd2);
      is_brick        <= in_range_q && (rd_data == 3'd3);
      is_pipe         <= in_range_q && (rd_data == 3'd4);
      barrier_address <= hit ? 11'(int'(tx_q) + int'(ty_q) * TILE_W) : '0;
    end
  end
endmodule
